// File: rtl/shift_pkg.sv
// Shared constants for the shift arbiter slice: default data width, shift-amount
// width derivation and requester-id encodings.
package shift_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  localparam logic ID_R0 = 1'b0;
  localparam logic ID_R1 = 1'b1;

  // Shift-amount width for a power-of-two data width.
  function automatic int unsigned amt_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_left.sv
// Combinational left barrel shifter; vacated LSBs are filled with sin.
module shift_left
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH = WIDTH_DEF,
  localparam int unsigned AMT_W = amt_w(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] fill;

  always_comb begin
    ones = '1;
    fill = sin ? ~(ones << amt) : '0;
    dout = (din << amt) | fill;
  end

endmodule

// File: rtl/shift_arb.sv
// Two-requester arbiter sharing one left shifter with a registered result stage.
// Define SHIFT_ARB_RR_EN for round-robin priority; otherwise r0 always wins.
module shift_arb
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH = WIDTH_DEF,
  localparam int unsigned AMT_W = amt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [AMT_W-1:0] r0_amt,
  input  logic [WIDTH-1:0] r0_in,
  input  logic             r0_sin,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [AMT_W-1:0] r1_amt,
  input  logic [WIDTH-1:0] r1_in,
  input  logic             r1_sin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id
);

  logic             free;
  logic             gnt_id;
  logic             acc;
  logic [WIDTH-1:0] op_in;
  logic [AMT_W-1:0] op_amt;
  logic             op_sin;
  logic [WIDTH-1:0] sh_out;

`ifdef SHIFT_ARB_RR_EN
  logic prio;
`endif

  // Grant selection, ready generation and shared-operand mux.
  always_comb begin
    free = !rsp_valid || rsp_ready;
`ifdef SHIFT_ARB_RR_EN
    // With no requester valid the grant parks on the current priority holder.
    if (r0_valid && r1_valid) gnt_id = prio;
    else if (r0_valid)        gnt_id = ID_R0;
    else if (r1_valid)        gnt_id = ID_R1;
    else                      gnt_id = prio;
`else
    gnt_id = (!r0_valid && r1_valid) ? ID_R1 : ID_R0;
`endif
    r0_ready = !rst && free && (gnt_id == ID_R0);
    r1_ready = !rst && free && (gnt_id == ID_R1);
    acc      = (r0_valid && r0_ready) || (r1_valid && r1_ready);
    op_in    = (gnt_id == ID_R1) ? r1_in  : r0_in;
    op_amt   = (gnt_id == ID_R1) ? r1_amt : r0_amt;
    op_sin   = (gnt_id == ID_R1) ? r1_sin : r0_sin;
  end

  shift_left #(
    .WIDTH (WIDTH)
  ) u_shift (
    .din  (op_in),
    .amt  (op_amt),
    .sin  (op_sin),
    .dout (sh_out)
  );

  // Result register: load on accept, clear on drain, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= ID_R0;
    end else if (acc) begin
      rsp_valid <= 1'b1;
      rsp_data  <= sh_out;
      rsp_id    <= gnt_id;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef SHIFT_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)      prio <= 1'b0;
    else if (acc) prio <= ~gnt_id;
  end
`endif

endmodule

// File: tb/tb_shift_arb.sv
// Self-checking bench for shift_arb: directed table, corner sequences and a
// randomized run against a behavioural model of the arbiter and shifter.
module tb_shift_arb;

`ifdef SHIFT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r1_valid, r0_ready, r1_ready;
  logic [4:0]  r0_amt, r1_amt;
  logic [31:0] r0_in, r1_in;
  logic        r0_sin, r1_sin;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_arb #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_amt(r0_amt), .r0_in(r0_in), .r0_sin(r0_sin),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_amt(r1_amt), .r1_in(r1_in), .r1_sin(r1_sin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  typedef struct {
    logic        r0v, r1v;
    logic [4:0]  a0, a1;
    logic [31:0] i0, i1;
    logic        s0, s1;
    logic        rr;
    logic        chk_rdy;
    logic        e0, e1;
    logic        ev;
    logic [31:0] ed;
    logic        eid;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v0, input logic v1, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] i0, input logic [31:0] i1,
                        input logic s0, input logic s1, input logic rr);
    r0_valid = v0; r1_valid = v1; r0_amt = a0; r1_amt = a1;
    r0_in = i0; r1_in = i1; r0_sin = s0; r1_sin = s1; rsp_ready = rr;
  endtask

  // Reference shift as plain arithmetic: multiply by 2^a, add a run of a fill ones.
  function automatic logic [31:0] ref_shl(input logic [31:0] x, input int a, input logic s);
    longint unsigned v;
    v = longint'(x) * (64'd1 << a);
    if (s) v = v + ((64'd1 << a) - 64'd1);
    return v[31:0];
  endfunction

  initial begin
    int exp_id;
    logic [31:0] held;
    logic m_valid, m_id, m_prio;
    logic [31:0] m_data;

    //        r0v  r1v  a0  a1  i0            i1            s0 s1 rr chk e0 e1 ev  ed            eid
    tbl[0] = '{1, 0, 4,  0,  32'h0000_00F0, 32'h0,        0, 0, 1, 1,  1, 0, 1, 32'h0000_0F00, 0};
    tbl[1] = '{0, 1, 0,  31, 32'h0,        32'h8000_0001, 0, 1, 1, 1,  0, 1, 1, 32'hFFFF_FFFF, 1};
    tbl[2] = '{0, 1, 0,  0,  32'h0,        32'h8000_0001, 0, 1, 1, 1,  0, 1, 1, 32'h8000_0001, 1};
    tbl[3] = '{0, 0, 0,  0,  32'h0,        32'h0,         0, 0, 1, 0,  0, 0, 0, 32'h0,         0};
    tbl[4] = '{1, 0, 8,  0,  32'h0000_0012, 32'h0,        1, 0, 1, 1,  1, 0, 1, 32'h0000_12FF, 0};
    tbl[5] = '{0, 1, 0,  4,  32'h0,        32'hF000_0000, 0, 0, 0, 1,  0, 0, 1, 32'h0000_12FF, 0};
    tbl[6] = '{0, 1, 0,  4,  32'h0,        32'hF000_0000, 0, 0, 1, 1,  0, 1, 1, 32'h0000_0000, 1};

    rst = 1'b1;
    set_in(1, 1, 0, 0, 32'h0, 32'h0, 0, 0, 1);
    #1;
    chk("rst_r0_ready", 32'(r0_ready), 0);
    chk("rst_r1_ready", 32'(r1_ready), 0);
    tick();
    tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    rst = 1'b0;

    // Directed table, applied from the reset state.
    for (int i = 0; i < 7; i++) begin
      set_in(tbl[i].r0v, tbl[i].r1v, tbl[i].a0, tbl[i].a1, tbl[i].i0, tbl[i].i1,
             tbl[i].s0, tbl[i].s1, tbl[i].rr);
      #1;
      if (tbl[i].chk_rdy) begin
        chk($sformatf("tbl%0d_r0_ready", i), 32'(r0_ready), 32'(tbl[i].e0));
        chk($sformatf("tbl%0d_r1_ready", i), 32'(r1_ready), 32'(tbl[i].e1));
      end
      tick();
      chk($sformatf("tbl%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_rsp_data", i), rsp_data, tbl[i].ed);
        chk($sformatf("tbl%0d_rsp_id", i), 32'(rsp_id), 32'(tbl[i].eid));
      end
    end

    // Both requesters valid with a free result stage: alternate or r0 only.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_in(1, 1, 5'(k), 5'(k), 32'h1, 32'h3, 0, 0, 1);
      exp_id = RR ? (k % 2) : 0;
      #1;
      chk($sformatf("both%0d_r0_ready", k), 32'(r0_ready), 32'(exp_id == 0));
      chk($sformatf("both%0d_r1_ready", k), 32'(r1_ready), 32'(exp_id == 1));
      tick();
      chk($sformatf("both%0d_rsp_valid", k), 32'(rsp_valid), 1);
      chk($sformatf("both%0d_rsp_id", k), 32'(rsp_id), 32'(exp_id));
      chk($sformatf("both%0d_rsp_data", k), rsp_data, (exp_id == 1 ? 32'h3 : 32'h1) << k);
    end
    held = (RR ? 32'h1 : 32'h1) << 4;

    // Consumer stalls: no grants, result and priority frozen.
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1, 5'd7, 5'd7, 32'hAAAA_5555, 32'h5555_AAAA, 1, 1, 0);
      #1;
      chk($sformatf("stall%0d_r0_ready", k), 32'(r0_ready), 0);
      chk($sformatf("stall%0d_r1_ready", k), 32'(r1_ready), 0);
      tick();
      chk($sformatf("stall%0d_rsp_valid", k), 32'(rsp_valid), 1);
      chk($sformatf("stall%0d_rsp_data", k), rsp_data, held);
      chk($sformatf("stall%0d_rsp_id", k), 32'(rsp_id), 0);
    end
    set_in(1, 1, 5'd1, 5'd1, 32'h10, 32'h20, 0, 0, 1);
    tick();
    chk("post_stall_id", 32'(rsp_id), RR ? 32'd1 : 32'd0);

    // Reset with a pending result, then both-valid arbitration restarts at r0.
    rst = 1'b1;
    set_in(1, 1, 5'd1, 5'd1, 32'h10, 32'h20, 0, 0, 0);
    #1;
    chk("midrst_r0_ready", 32'(r0_ready), 0);
    chk("midrst_r1_ready", 32'(r1_ready), 0);
    tick();
    rst = 1'b0;
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_rsp_data", rsp_data, 0);
    set_in(1, 1, 5'd1, 5'd1, 32'h10, 32'h20, 0, 0, 1);
    tick();
    chk("afterrst_id0", 32'(rsp_id), 0);
    chk("afterrst_data0", rsp_data, 32'h20);
    tick();
    chk("afterrst_id1", 32'(rsp_id), RR ? 32'd1 : 32'd0);

    // Randomized traffic against the behavioural model.
    m_valid = 0; m_data = 0; m_id = 0; m_prio = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic do_rst, free, acc, win;
      do_rst = ($urandom_range(0, 49) == 0);
      rst = do_rst;
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
             5'($urandom), 5'($urandom), $urandom, $urandom,
             1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) < 7));
      #1;
      free = !m_valid || rsp_ready;
      win  = (r0_valid && r1_valid) ? (RR ? m_prio : 1'b0) : !r0_valid;
      acc  = 1'b0;
      if (do_rst) begin
        chk("rnd_rst_r0_ready", 32'(r0_ready), 0);
        chk("rnd_rst_r1_ready", 32'(r1_ready), 0);
      end else if (r0_valid || r1_valid) begin
        chk("rnd_r0_ready", 32'(r0_ready), 32'(free && !win));
        chk("rnd_r1_ready", 32'(r1_ready), 32'(free && win));
        acc = free;
      end else begin
        chk("rnd_idle_onehot", 32'(r0_ready && r1_ready), 0);
      end
      if (do_rst) begin
        m_valid = 0; m_data = 0; m_id = 0; m_prio = 0;
      end else if (acc) begin
        m_valid = 1;
        m_id    = win;
        m_data  = win ? ref_shl(r1_in, int'(r1_amt), r1_sin) : ref_shl(r0_in, int'(r0_amt), r0_sin);
        m_prio  = !win;
      end else if (rsp_ready) begin
        m_valid = 0;
      end
      tick();
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid || do_rst) begin
        chk("rnd_rsp_data", rsp_data, m_data);
        chk("rnd_rsp_id", 32'(rsp_id), 32'(m_id));
      end
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
